// File: rtl/integer_exec_unit.sv
// integer_exec_unit: RV32I/RV64I ALU ops in one cycle plus iterative radix-2 M-extension
// multiply/divide, behind valid/ready handshakes on both the op and the result side.
module integer_exec_unit #(
    parameter int XLEN = 32,
    localparam int SHW = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            i_valid,
    output logic            o_ready,
    input  logic            i_flush,
    input  logic            i_imm_sel,
    input  logic            i_m_sel,
    input  logic [3:0]      i_op,
    input  logic [XLEN-1:0] i_rs1,
    input  logic [XLEN-1:0] i_rs2,
    input  logic [XLEN-1:0] i_imm,
    output logic            o_valid,
    input  logic            i_ready,
    output logic [XLEN-1:0] o_res_data,
    output logic            o_res_zero,
    output logic            o_illegal
);
    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_e;

    state_e          state_q, state_d;
    logic [SHW-1:0]  cnt_q, cnt_d;
    logic            valid_q, valid_d, zero_q, zero_d, ill_q, ill_d;
    logic [XLEN-1:0] data_q, data_d;
    logic [2:0]      op_q, op_d;
    logic            neg_q, neg_d, nrem_q, nrem_d, bz_q, bz_d;
    logic [XLEN-1:0] a_q, a_d, hi_q, hi_d, lo_q, lo_d;

    logic [XLEN-1:0]   b, alu_res, abs_a, abs_b, quo_c, rem_c, m_res;
    logic [SHW-1:0]    shamt;
    logic [2:0]        f3;
    logic              illegal, accept, sgn_a, sgn_b, sa, sb, ge;
    logic [XLEN:0]     sum, rs;
    logic [2*XLEN-1:0] prod_c;

    assign b       = i_imm_sel ? i_imm : i_rs2;
    assign shamt   = b[SHW-1:0];
    assign illegal = i_op > 4'd9;
    assign o_ready = rstn && !i_flush && state_q == IDLE && (!valid_q || i_ready);
    assign accept  = i_valid && o_ready;

    always_comb begin
        alu_res = '0;
        case (i_op)
            4'd0: alu_res = i_rs1 + b;
            4'd1: alu_res = i_rs1 - b;
            4'd2: alu_res = {{(XLEN-1){1'b0}}, $signed(i_rs1) < $signed(b)};
            4'd3: alu_res = {{(XLEN-1){1'b0}}, i_rs1 < b};
            4'd4: alu_res = i_rs1 ^ b;
            4'd5: alu_res = i_rs1 | b;
            4'd6: alu_res = i_rs1 & b;
            4'd7: alu_res = i_rs1 << shamt;
            4'd8: alu_res = i_rs1 >> shamt;
            4'd9: alu_res = $signed(i_rs1) >>> shamt;
            default: alu_res = '0;
        endcase
    end

    // MULHU, DIVU and REMU treat both operands as unsigned; MULHSU only rs2.
    assign f3    = i_op[2:0];
    assign sgn_a = !(f3 == 3'd3 || (f3[2] && f3[0]));
    assign sgn_b = sgn_a && f3 != 3'd2;
    assign sa    = sgn_a && i_rs1[XLEN-1];
    assign sb    = sgn_b && b[XLEN-1];
    assign abs_a = sa ? -i_rs1 : i_rs1;
    assign abs_b = sb ? -b : b;

    assign sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, a_q} : '0);
    assign rs  = {hi_q, lo_q[XLEN-1]};
    assign ge  = rs >= {1'b0, a_q};

    assign prod_c = neg_q ? -{hi_q, lo_q} : {hi_q, lo_q};
    assign quo_c  = bz_q ? '1 : (neg_q ? -lo_q : lo_q);
    assign rem_c  = nrem_q ? -hi_q : hi_q;
    assign m_res  = op_q[2] ? (op_q[1] ? rem_c : quo_c)
                            : (op_q[1:0] == 2'd0 ? prod_c[XLEN-1:0] : prod_c[2*XLEN-1:XLEN]);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        neg_d   = neg_q;
        nrem_d  = nrem_q;
        bz_d    = bz_q;
        a_d     = a_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        valid_d = valid_q && !i_ready;
        data_d  = data_q;
        ill_d   = ill_q;
        case (state_q)
            IDLE: if (accept && i_m_sel) begin
                op_d    = f3;
                neg_d   = sa ^ sb;
                nrem_d  = sa;
                bz_d    = b == '0;
                cnt_d   = '0;
                hi_d    = '0;
                a_d     = f3[2] ? abs_b : abs_a;
                lo_d    = f3[2] ? abs_a : abs_b;
                state_d = f3[2] ? DIV : MUL;
            end
            MUL: begin
                hi_d    = sum[XLEN:1];
                lo_d    = {sum[0], lo_q[XLEN-1:1]};
                cnt_d   = cnt_q + 1'b1;
                state_d = cnt_q == SHW'(XLEN - 1) ? DONE : MUL;
            end
            DIV: begin
                hi_d    = ge ? XLEN'(rs - {1'b0, a_q}) : rs[XLEN-1:0];
                lo_d    = {lo_q[XLEN-2:0], ge};
                cnt_d   = cnt_q + 1'b1;
                state_d = cnt_q == SHW'(XLEN - 1) ? DONE : DIV;
            end
            DONE: begin
                valid_d = 1'b1;
                data_d  = m_res;
                ill_d   = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (accept && !i_m_sel) begin
            valid_d = 1'b1;
            data_d  = illegal ? '0 : alu_res;
            ill_d   = illegal;
        end
        zero_d = ~|data_d;
        if (i_flush) begin
            state_d = IDLE;
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
            zero_q  <= 1'b0;
            ill_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            zero_q  <= zero_d;
            ill_q   <= ill_d;
        end
    end

    // Datapath registers carry no reset; they are always loaded before being read.
    always_ff @(posedge clk) begin
        op_q   <= op_d;
        neg_q  <= neg_d;
        nrem_q <= nrem_d;
        bz_q   <= bz_d;
        a_q    <= a_d;
        hi_q   <= hi_d;
        lo_q   <= lo_d;
    end

    assign o_valid    = valid_q;
    assign o_res_data = data_q;
    assign o_res_zero = zero_q;
    assign o_illegal  = ill_q;
endmodule

// File: tb/tb_integer_exec_unit.sv
// tb_integer_exec_unit: directed tests of the integer execution unit at XLEN=32 with
// hand-computed expected results and M-op latency checks.
module tb_integer_exec_unit;
    logic        clk = 1'b0;
    logic        rstn, i_valid, o_ready, i_flush, i_imm_sel, i_m_sel;
    logic [3:0]  i_op;
    logic [31:0] i_rs1, i_rs2, i_imm, o_res_data;
    logic        o_valid, i_ready, o_res_zero, o_illegal;
    int          tests = 0;
    int          fails = 0;

    typedef struct {
        logic [2:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } mvec_t;

    always #5 clk = ~clk;

    integer_exec_unit #(.XLEN(32)) dut (
        .clk(clk), .rstn(rstn), .i_valid(i_valid), .o_ready(o_ready), .i_flush(i_flush),
        .i_imm_sel(i_imm_sel), .i_m_sel(i_m_sel), .i_op(i_op), .i_rs1(i_rs1), .i_rs2(i_rs2),
        .i_imm(i_imm), .o_valid(o_valid), .i_ready(i_ready), .o_res_data(o_res_data),
        .o_res_zero(o_res_zero), .o_illegal(o_illegal)
    );

    task automatic drive(input logic m, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] bb, input logic imm);
        i_valid   = 1'b1;
        i_m_sel   = m;
        i_op      = op;
        i_rs1     = a;
        i_imm_sel = imm;
        i_rs2     = imm ? 32'hDEAD_BEEF : bb;
        i_imm     = imm ? bb : 32'h1234_5678;
    endtask

    task automatic test_reset();
        rstn = 1'b0; i_flush = 1'b0; i_ready = 1'b1;
        drive(1'b0, 4'd0, 32'd1, 32'd2, 1'b0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            tests++;
            if (o_valid !== 1'b0 || o_res_data !== 32'd0 || o_ready !== 1'b0) begin
                fails++;
                $display("FAIL reset_hold: valid=%b data=%h ready=%b, want 0 0 0", o_valid, o_res_data, o_ready);
            end
        end
        rstn = 1'b1; i_valid = 1'b0;
        #1;
        tests++;
        if (o_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_release_ready: got %b want 1", o_ready);
        end
    endtask

    task automatic test_alu_stream();
        @(negedge clk);
        drive(1'b0, 4'd0, 32'd7, 32'd5, 1'b0);
        @(negedge clk);
        tests++;
        if (o_valid !== 1'b1 || o_res_data !== 32'd12 || o_res_zero !== 1'b0) begin
            fails++;
            $display("FAIL alu_add: valid=%b data=%h zero=%b want 1 0000000c 0", o_valid, o_res_data, o_res_zero);
        end
        drive(1'b0, 4'd1, 32'd5, 32'd5, 1'b0);
        @(negedge clk);
        tests++;
        if (o_valid !== 1'b1 || o_res_data !== 32'd0 || o_res_zero !== 1'b1) begin
            fails++;
            $display("FAIL alu_sub_zero: valid=%b data=%h zero=%b want 1 0 1", o_valid, o_res_data, o_res_zero);
        end
        drive(1'b0, 4'd9, 32'h8000_0000, 32'h21, 1'b1);
        @(negedge clk);
        tests++;
        if (o_valid !== 1'b1 || o_res_data !== 32'hC000_0000) begin
            fails++;
            $display("FAIL alu_sra_imm: valid=%b data=%h want 1 c0000000", o_valid, o_res_data);
        end
        i_valid = 1'b0;
    endtask

    task automatic test_alu_misc();
        logic [3:0]  ops [6] = '{4'd2, 4'd3, 4'd7, 4'd8, 4'd6, 4'd12};
        logic [31:0] as  [6] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0003, 32'h8000_0000, 32'hF0F0_1234, 32'h5555_5555};
        logic [31:0] bs  [6] = '{32'd1, 32'd1, 32'h0000_0021, 32'h0000_003F, 32'h0FF0_FF00, 32'd1};
        logic [31:0] ex  [6] = '{32'd1, 32'd0, 32'h0000_0006, 32'h0000_0001, 32'h00F0_1200, 32'd0};
        logic        il  [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            drive(1'b0, ops[k], as[k], bs[k], 1'b0);
            @(negedge clk);
            i_valid = 1'b0;
            tests++;
            if (o_valid !== 1'b1 || o_res_data !== ex[k] || o_illegal !== il[k]) begin
                fails++;
                $display("FAIL alu_misc op=%0d: valid=%b data=%h ill=%b want 1 %h %b", ops[k], o_valid, o_res_data, o_illegal, ex[k], il[k]);
            end
        end
    endtask

    task automatic test_backpressure();
        @(negedge clk);
        i_ready = 1'b0;
        drive(1'b0, 4'd4, 32'hF0F0_F0F0, 32'hFFFF_FFFF, 1'b0);
        @(negedge clk);
        tests++;
        if (o_valid !== 1'b1 || o_res_data !== 32'h0F0F_0F0F || o_ready !== 1'b0) begin
            fails++;
            $display("FAIL bp_first: valid=%b data=%h ready=%b want 1 0f0f0f0f 0", o_valid, o_res_data, o_ready);
        end
        drive(1'b0, 4'd5, 32'd1, 32'd2, 1'b0);
        @(negedge clk);
        tests++;
        if (o_valid !== 1'b1 || o_res_data !== 32'h0F0F_0F0F || o_ready !== 1'b0) begin
            fails++;
            $display("FAIL bp_hold: valid=%b data=%h ready=%b want 1 0f0f0f0f 0", o_valid, o_res_data, o_ready);
        end
        i_ready = 1'b1;
        #1;
        tests++;
        if (o_ready !== 1'b1) begin
            fails++;
            $display("FAIL bp_release_ready: got %b want 1", o_ready);
        end
        @(negedge clk);
        i_valid = 1'b0;
        tests++;
        if (o_valid !== 1'b1 || o_res_data !== 32'd3) begin
            fails++;
            $display("FAIL bp_next_op: valid=%b data=%h want 1 00000003", o_valid, o_res_data);
        end
        @(negedge clk);
        tests++;
        if (o_valid !== 1'b0) begin
            fails++;
            $display("FAIL bp_drain: valid=%b want 0", o_valid);
        end
    endtask

    task automatic test_mdu();
        mvec_t v [13];
        int    n;
        v[0]  = '{3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000};
        v[1]  = '{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
        v[2]  = '{3'd0, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000};
        v[3]  = '{3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        v[4]  = '{3'd0, 32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB};
        v[5]  = '{3'd4, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD};
        v[6]  = '{3'd6, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF};
        v[7]  = '{3'd5, 32'd9,         32'd0,         32'hFFFF_FFFF};
        v[8]  = '{3'd7, 32'd9,         32'd0,         32'd9};
        v[9]  = '{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000};
        v[10] = '{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000};
        v[11] = '{3'd4, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFFF};
        v[12] = '{3'd7, 32'd100,       32'd3,         32'd1};
        for (int k = 0; k < 13; k++) begin
            @(negedge clk);
            drive(1'b1, {1'b0, v[k].f}, v[k].a, v[k].b, 1'b0);
            @(posedge clk);
            #1 i_valid = 1'b0;
            n = 0;
            for (int c = 1; c <= 40; c++) begin
                @(posedge clk);
                #1;
                if (o_valid === 1'b1) begin
                    n = c;
                    break;
                end
            end
            tests++;
            if (n != 33 || o_res_data !== v[k].exp) begin
                fails++;
                $display("FAIL mdu f3=%0d a=%h b=%h: data=%h after %0d cycles, want %h after 33", v[k].f, v[k].a, v[k].b, o_res_data, n, v[k].exp);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_flush();
        int seen;
        @(negedge clk);
        drive(1'b1, 4'd5, 32'd100, 32'd3, 1'b0);
        @(posedge clk);
        #1 i_valid = 1'b0;
        seen = 0;
        repeat (9) begin
            @(posedge clk);
            #1 if (o_valid === 1'b1) seen++;
        end
        @(negedge clk);
        i_flush = 1'b1;
        drive(1'b0, 4'd0, 32'd50, 32'd50, 1'b0);
        #1;
        tests++;
        if (o_ready !== 1'b0) begin
            fails++;
            $display("FAIL flush_masks_ready: got %b want 0", o_ready);
        end
        @(negedge clk);
        i_flush = 1'b0;
        i_valid = 1'b0;
        #1;
        tests++;
        if (o_ready !== 1'b1 || o_valid !== 1'b0) begin
            fails++;
            $display("FAIL flush_idle: ready=%b valid=%b want 1 0", o_ready, o_valid);
        end
        drive(1'b0, 4'd0, 32'd1, 32'd1, 1'b0);
        @(negedge clk);
        i_valid = 1'b0;
        tests++;
        if (o_valid !== 1'b1 || o_res_data !== 32'd2) begin
            fails++;
            $display("FAIL flush_then_add: valid=%b data=%h want 1 00000002", o_valid, o_res_data);
        end
        repeat (40) begin
            @(negedge clk);
            if (o_valid === 1'b1) seen++;
        end
        tests++;
        if (seen != 0) begin
            fails++;
            $display("FAIL flush_no_result: %0d stray valid cycles, want 0", seen);
        end
        drive(1'b0, 4'd0, 32'd4, 32'd4, 1'b0);
        @(negedge clk);
        i_valid = 1'b0;
        i_ready = 1'b0;
        i_flush = 1'b1;
        @(negedge clk);
        i_flush = 1'b0;
        i_ready = 1'b1;
        tests++;
        if (o_valid !== 1'b0) begin
            fails++;
            $display("FAIL flush_drops_result: valid=%b want 0", o_valid);
        end
    endtask

    initial begin
        test_reset();
        test_alu_stream();
        test_alu_misc();
        test_backpressure();
        test_mdu();
        test_flush();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/integer_exec_unit.md
Name: integer_exec_unit

Overview:
- Parametrised successor to the single-cycle integer ALU: executes the RV32I/RV64I register and immediate ALU operations, plus the M-extension multiply, divide and remainder operations, behind a valid/ready handshake.
- Base ALU ops complete in 1 cycle.
- M ops run on an iterative radix-2 multiplier/divider controlled by an FSM.
- Sits between decode/register-file read and writeback; the pipeline stalls on o_ready.

Parameters:
- XLEN, 32, datapath width; legal values are 32 and 64.
- SHW, $clog2(XLEN), shift-amount width; derived, not overridable.

Ports:
- clk  in  1  clock
- rstn  in  1  synchronous active-low reset
- i_valid  in  1  operation offered
- o_ready  out  1  unit can accept an operation this cycle
- i_flush  in  1  abort the in-flight op and drop the pending result
- i_imm_sel  in  1  B operand = i_imm (1) or i_rs2 (0)
- i_m_sel  in  1  1 = M-extension op, 0 = base ALU op
- i_op  in  4  base: Add=0, Sub=1, Slt=2, Sltu=3, Xor=4, Or=5, And=6, Sll=7, Srl=8, Sra=9; M: i_op[2:0] = funct3 (MUL..REMU)
- i_rs1  in  XLEN  A operand
- i_rs2  in  XLEN  B operand (register)
- i_imm  in  XLEN  B operand (immediate)
- o_valid  out  1  result valid
- i_ready  in  1  downstream accepts the result
- o_res_data  out  XLEN  result
- o_res_zero  out  1  result == 0
- o_illegal  out  1  with o_valid: unsupported base opcode (10..15)

Behaviour:
- Reset (rstn=0 at a clk edge): state=IDLE, o_valid=0, o_res_data=0, o_res_zero=0, o_illegal=0, counter=0. Reset wins over every other input.
- Handshake:
  - An op is accepted when i_valid && o_ready.
  - o_ready = (state==IDLE) && (!o_valid || i_ready).
  - The result is consumed when o_valid && i_ready.
  - While o_valid && !i_ready, o_res_data, o_res_zero and o_illegal hold stable.
- Base ALU op: registered. o_valid=1 in the cycle after acceptance. Back-to-back ops give 1 result per cycle.
- Shifts:
  - The shift amount is b[SHW-1:0]; upper bits are ignored.
  - Sra is arithmetic.
  - Slt/Sltu produce a zero-extended 1-bit result.
- Illegal base op: o_res_data=0, o_illegal=1, o_valid asserted normally. Never stalls.
- FSM states: IDLE, MUL, DIV, DONE.
  - IDLE: accepting an M op latches operand magnitudes and sign flags, clears the counter, and moves to MUL (funct3 0-3) or DIV (funct3 4-7).
  - MUL/DIV: one shift-add or shift-subtract step per cycle. After XLEN steps (counter==XLEN-1), move to DONE.
  - DONE: applies sign correction, registers the result, sets o_valid, and returns to IDLE. Total latency is XLEN+1 cycles from the accept edge to o_valid high.
- MUL returns the low XLEN bits of the product.
- MULH, MULHSU and MULHU return the high XLEN bits, with signed×signed, signed×unsigned and unsigned×unsigned operands respectively.
- Divide by zero: quotient = all ones (DIV and DIVU), remainder = dividend. The full XLEN+1 latency still applies.
- Signed overflow (DIV/REM of the most-negative value by -1): quotient = dividend, remainder = 0.
- Signed remainder takes the sign of the dividend. Quotient truncates toward zero.
- i_flush:
  - Forces state=IDLE and o_valid=0 at the next edge.
  - The in-flight result is discarded.
  - An op offered in the same cycle as i_flush is not accepted (o_ready is masked by i_flush).
- o_res_zero = ~|o_res_data, registered together with the data.
- No X propagation: unused datapath registers hold their value.

Test Plan:
- Reset: hold rstn=0 for 3 cycles with i_valid=1 → o_valid=0, o_res_data=0, o_ready=0 during reset; o_ready=1 on the first cycle after release.
- ALU streaming: Add 7+5, then Sub 5-5, then Sra 0x80000000 by 0x21, i_ready=1 → results 12, 0 (o_res_zero=1), 0xC0000000 (shift amount 1), on 3 consecutive cycles.
- Backpressure: i_ready=0 while o_valid=1 with Xor 0xF0F0F0F0^0xFFFFFFFF → o_res_data holds 0x0F0F0F0F and o_ready=0 until i_ready=1; the next op is accepted that cycle.
- Multiply: MULH 0xFFFFFFFF×0xFFFFFFFF → 0x00000000, o_valid exactly 33 cycles after accept. MULHU of the same operands → 0xFFFFFFFE. MUL 0x10000×0x10000 → 0.
- Divide corners: DIV -7/2 → 0xFFFFFFFD, REM → 0xFFFFFFFF; DIVU 9/0 → 0xFFFFFFFF, REMU → 9; DIV 0x80000000/-1 → 0x80000000, REM → 0.
- Flush: start DIVU 100/3 and assert i_flush at cycle 10 → no o_valid for that op; o_ready=1 the next cycle; a following Add 1+1 returns 2 with 1-cycle latency.
